// File: rtl/m68k_bus_pkg.sv
// Shared types and helpers for the 68000 bus controller: FSM state encoding and
// width helpers for the packed per-slave parameter slots.
package m68k_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StAck,
    StVpa,
    StErr
  } bus_state_e;

  localparam int WAIT_W = 4;

  function automatic int field_width(input int hi, input int lo);
    return hi - lo + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/m68k_addr_decode.sv
// Priority address decoder: compares the decode field against every slave base and
// reports the lowest matching slave index.
module m68k_addr_decode
  import m68k_bus_pkg::*;
#(
  parameter int                         NUM_SLAVES = 4,
  parameter int                         FW         = 4,
  parameter logic [NUM_SLAVES*FW-1:0]   BASES      = '0
) (
  input  logic [FW-1:0]                       field,
  output logic                                hit,
  output logic [idx_width(NUM_SLAVES)-1:0]    idx
);

  localparam int IW = idx_width(NUM_SLAVES);

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (field == BASES[i*FW +: FW]) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/m68k_bus_ctrl.sv
// 68000 bus controller: chip selects, DTACK with per-slave wait states and optional
// slave ready, VPA cycles, bus error on unmapped address or timeout, read data mux.
module m68k_bus_ctrl
  import m68k_bus_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_HI    = 15,
  parameter int ADDR_LO    = 12,
  parameter logic [NUM_SLAVES*field_width(ADDR_HI, ADDR_LO)-1:0] BASES = 16'h3210,
  parameter logic [NUM_SLAVES*WAIT_W-1:0] WAITS    = 16'h0011,
  parameter logic [NUM_SLAVES-1:0]        VPA_MASK = 4'b1000,
  parameter logic [NUM_SLAVES-1:0]        ACK_MASK = 4'b0000,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       as_n,
  input  logic                       rw,
  input  logic [23:1]                addr,
  input  logic [NUM_SLAVES*16-1:0]   slave_dout,
  input  logic [NUM_SLAVES-1:0]      slave_ack,
  output logic [NUM_SLAVES-1:0]      cs,
  output logic                       we,
  output logic [15:0]                cpu_din,
  output logic                       dtack_n,
  output logic                       vpa_n,
  output logic                       berr_n
);

  localparam int FW = field_width(ADDR_HI, ADDR_LO);
  localparam int IW = idx_width(NUM_SLAVES);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  bus_state_e            state_q;
  logic [NUM_SLAVES-1:0] cs_q;
  logic                  dtack_n_q, vpa_n_q, berr_n_q;
  logic [WAIT_W-1:0]     wait_q;
  logic [TW-1:0]         tmo_q;
  logic [IW-1:0]         sel_q;

  logic                  hit;
  logic [IW-1:0]         idx;
  logic [NUM_SLAVES-1:0] onehot;
  logic                  ack_ok;

  m68k_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .FW         (FW),
    .BASES      (BASES)
  ) u_decode (
    .field (addr[ADDR_HI:ADDR_LO]),
    .hit   (hit),
    .idx   (idx)
  );

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
    ack_ok      = !ACK_MASK[sel_q] || slave_ack[sel_q];
  end

  // A strobe release behaves exactly like reset: every output goes inactive at that edge.
  always_ff @(posedge clk) begin
    if (reset || as_n) begin
      state_q   <= StIdle;
      cs_q      <= '0;
      dtack_n_q <= 1'b1;
      vpa_n_q   <= 1'b1;
      berr_n_q  <= 1'b1;
      wait_q    <= '0;
      tmo_q     <= '0;
      sel_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!hit) begin
            state_q <= StErr;
          end else begin
            cs_q  <= onehot;
            sel_q <= idx;
            if (VPA_MASK[idx]) begin
              state_q <= StVpa;
            end else begin
              wait_q  <= WAITS[idx*WAIT_W +: WAIT_W];
              tmo_q   <= '0;
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (tmo_q != TMO_MAX) tmo_q <= tmo_q + 1'b1;
          // Timeout wins over a DTACK grant that would land on the same edge.
          if (tmo_q >= TMO_LAST) begin
            berr_n_q <= 1'b0;
            cs_q     <= '0;
            state_q  <= StErr;
          end else if (wait_q == '0 && ack_ok) begin
            dtack_n_q <= 1'b0;
            state_q   <= StAck;
          end else if (wait_q != '0) begin
            wait_q <= wait_q - 1'b1;
          end
        end
        StVpa:   vpa_n_q  <= 1'b0;
        StErr:   berr_n_q <= 1'b0;
        StAck:   state_q  <= StAck;
        default: state_q  <= StIdle;
      endcase
    end
  end

  always_comb begin
    cpu_din = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (cs_q[i]) cpu_din = cpu_din | slave_dout[i*16 +: 16];
    end
  end

  assign cs      = cs_q;
  assign we      = (|cs_q) & ~rw;
  assign dtack_n = dtack_n_q;
  assign vpa_n   = vpa_n_q;
  assign berr_n  = berr_n_q;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Bench for m68k_bus_ctrl: directed vector table, a mid-cycle reset sequence and
// randomized transactions checked cycle by cycle against a rule-based model.
module tb_m68k_bus_ctrl;

  localparam int NS  = 6;
  localparam int TMO = 20;
  localparam int NEVER = 999;

  // Bench view of the slave map (slot 5 duplicates base 1 to exercise priority).
  int bases [NS] = '{0, 1, 2, 3, 4, 1};
  int waits [NS] = '{3, 1, 0, 0, 1, 2};
  bit vpam  [NS] = '{0, 0, 0, 1, 0, 0};
  bit ackm  [NS] = '{0, 0, 0, 0, 1, 0};

  typedef struct {
    logic [23:0] baddr;
    logic        rw;
    int          hold;
    int          ack_at;
    logic [5:0]  cs;
    int          dtack_at;
    int          vpa_at;
    int          berr_at;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, as_n, rw;
  logic [23:1]      addr;
  logic [NS*16-1:0] slave_dout;
  logic [NS-1:0]    slave_ack;
  logic [NS-1:0]    cs;
  logic             we, dtack_n, vpa_n, berr_n;
  logic [15:0]      cpu_din;
  logic [15:0]      dout [NS];

  int checks = 0;
  int errors = 0;

  always_comb begin
    slave_dout = '0;
    for (int i = 0; i < NS; i++) slave_dout[i*16 +: 16] = dout[i];
  end

  m68k_bus_ctrl #(
    .NUM_SLAVES (NS),
    .ADDR_HI    (15),
    .ADDR_LO    (12),
    .BASES      (24'h143210),
    .WAITS      (24'h210013),
    .VPA_MASK   (6'b001000),
    .ACK_MASK   (6'b010000),
    .TIMEOUT    (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .as_n       (as_n),
    .rw         (rw),
    .addr       (addr),
    .slave_dout (slave_dout),
    .slave_ack  (slave_ack),
    .cs         (cs),
    .we         (we),
    .cpu_din    (cpu_din),
    .dtack_n    (dtack_n),
    .vpa_n      (vpa_n),
    .berr_n     (berr_n)
  );

  function automatic logic [31:0] got();
    return {6'b0, cs, dtack_n, vpa_n, berr_n, we, cpu_din};
  endfunction

  function automatic logic [31:0] exp_pack(logic [5:0] c, logic d, logic v, logic b, logic r);
    logic [15:0] din = '0;
    for (int i = 0; i < NS; i++) if (c[i]) din = din | dout[i];
    return {6'b0, c, d, v, b, (|c) & ~r, din};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {cs,dtack,vpa,berr,we,din}=%h expected %h", name, act, exp);
    end
  endtask

  // Slave 4 is the only ACK-gated slot; the other ack bits carry noise that must be ignored.
  task automatic set_ack(int m, int a);
    slave_ack    = NS'($urandom);
    slave_ack[4] = (m >= a);
  endtask

  // Expected outputs k edges after E0, derived from the transaction's event times.
  function automatic logic [31:0] exp_at(vec_t v, int k);
    logic [5:0] c = (k >= v.berr_at) ? 6'b0 : v.cs;
    return exp_pack(c, !(k >= v.dtack_at), !(k >= v.vpa_at), !(k >= v.berr_at), v.rw);
  endfunction

  // Drive one bus cycle starting from idle at a negedge; check every edge and the release.
  task automatic run(vec_t v, string name);
    addr = v.baddr[23:1];
    rw   = v.rw;
    as_n = 1'b0;
    set_ack(0, v.ack_at);
    for (int m = 0; m < v.hold; m++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s k=%0d", name, m), got(), exp_at(v, m));
      set_ack(m + 1, v.ack_at);
      if (m + 1 >= v.hold) as_n = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check({name, " release"}, got(), exp_pack(6'b0, 1'b1, 1'b1, 1'b1, rw));
  endtask

  // Reference model: event times computed from the bus rules.
  function automatic vec_t model(logic [23:0] ba, logic r, int hold, int a);
    vec_t v;
    int   idx = -1;
    int   d;
    v.baddr = ba; v.rw = r; v.hold = hold; v.ack_at = a;
    v.cs = '0; v.dtack_at = NEVER; v.vpa_at = NEVER; v.berr_at = NEVER;
    for (int i = 0; i < NS; i++) if (idx < 0 && bases[i] == int'(ba[15:12])) idx = i;
    if (idx < 0) begin
      v.berr_at = 1;
    end else begin
      v.cs = 6'b1 << idx;
      if (vpam[idx]) begin
        v.vpa_at = 1;
      end else begin
        d = waits[idx] + 1;
        if (ackm[idx] && a > d) d = a;
        if (d >= TMO) v.berr_at = TMO;
        else          v.dtack_at = d;
      end
    end
    return v;
  endfunction

  vec_t table_v [12];

  initial begin
    reset = 1'b1; as_n = 1'b1; rw = 1'b1; addr = '0; slave_ack = '0;
    dout = '{16'h1111, 16'hBEEF, 16'h2222, 16'h3333, 16'h4444, 16'h5555};

    //                addr      rw    hold ack  cs          dtack  vpa    berr
    table_v[0]  = '{24'h001000, 1'b1, 5,  NEVER, 6'b000010, 2,     NEVER, NEVER};
    table_v[1]  = '{24'h002000, 1'b0, 4,  NEVER, 6'b000100, 1,     NEVER, NEVER};
    table_v[2]  = '{24'h003002, 1'b1, 4,  NEVER, 6'b001000, NEVER, 1,     NEVER};
    table_v[3]  = '{24'h005000, 1'b1, 3,  NEVER, 6'b000000, NEVER, NEVER, 1};
    table_v[4]  = '{24'h004000, 1'b1, 23, NEVER, 6'b010000, NEVER, NEVER, 20};
    table_v[5]  = '{24'h004000, 1'b1, 9,  6,     6'b010000, 6,     NEVER, NEVER};
    table_v[6]  = '{24'h004000, 1'b0, 4,  0,     6'b010000, 2,     NEVER, NEVER};
    table_v[7]  = '{24'h000000, 1'b1, 2,  NEVER, 6'b000001, NEVER, NEVER, NEVER};
    table_v[8]  = '{24'h000000, 1'b1, 6,  NEVER, 6'b000001, 4,     NEVER, NEVER};
    table_v[9]  = '{24'h00F000, 1'b0, 3,  NEVER, 6'b000000, NEVER, NEVER, 1};
    table_v[10] = '{24'h0A1FFE, 1'b1, 3,  NEVER, 6'b000010, 2,     NEVER, NEVER};
    table_v[11] = '{24'h002000, 1'b1, 1,  NEVER, 6'b000100, NEVER, NEVER, NEVER};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", got(), exp_pack(6'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);

    foreach (table_v[i]) run(table_v[i], $sformatf("vec%0d", i));

    // Reset landing mid-WAIT on slave 0 (three wait states).
    addr = '0; rw = 1'b1; as_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid e0", got(), exp_pack(6'b000001, 1'b1, 1'b1, 1'b1, 1'b1));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid forced", got(), exp_pack(6'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    reset = 1'b0; as_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid idle", got(), exp_pack(6'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    run(model(24'h000000, 1'b1, 6, NEVER), "rst_mid fresh");

    for (int t = 0; t < 60; t++) begin
      logic [23:0] ba;
      int          a;
      ba = 24'($urandom) & 24'hFFFFFE;
      if ($urandom_range(2) == 0) ba[15:12] = 4'h4;
      a = ($urandom_range(3) == 0) ? NEVER : int'($urandom_range(23));
      for (int i = 0; i < NS; i++) dout[i] = 16'($urandom);
      run(model(ba, 1'($urandom), 1 + int'($urandom_range(23)), a), $sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion within 200000 time units");
    $fatal(1);
  end

endmodule
